// File: rtl/nway_dcache_ctrl.sv
// N-way set-associative write-back / write-allocate data-cache controller with
// round-robin replacement and saturating hit/miss statistics.
//
// state     | meaning
// IDLE      | lookup; hits serviced combinationally, miss latches tag/index/victim
// WRITEBACK | dirty victim block written to RAM, wait for ram_ready
// ALLOCATE  | refill block read from RAM into the victim way, wait for ram_ready
module nway_dcache_ctrl #(
  parameter int OFFSET_WIDTH = 3,
  parameter int INDEX_WIDTH  = 6,
  parameter int ADDR_WIDTH   = 30,
  parameter int DATA_WIDTH   = 32,
  parameter int WAYS         = 2,
  parameter int CNT_WIDTH    = 32,
  localparam int BLOCK_SIZE  = 1 << OFFSET_WIDTH,
  localparam int SETS        = 1 << INDEX_WIDTH,
  localparam int BLOCK_WIDTH = DATA_WIDTH * BLOCK_SIZE,
  localparam int TAG_WIDTH   = ADDR_WIDTH - OFFSET_WIDTH - INDEX_WIDTH,
  localparam int BE_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dc_read_in,
  input  logic                   dc_write_in,
  input  logic [BE_WIDTH-1:0]    dc_byte_w_en_in,
  input  logic [ADDR_WIDTH-1:0]  dc_addr,
  input  logic [DATA_WIDTH-1:0]  data_from_reg,
  input  logic                   ram_ready,
  input  logic [BLOCK_WIDTH-1:0] block_from_ram,
  output logic                   mem_stall,
  output logic [DATA_WIDTH-1:0]  dc_data_out,
  output logic [2:0]             status,
  output logic                   ram_en_out,
  output logic                   ram_write_out,
  output logic [ADDR_WIDTH-1:0]  ram_addr_out,
  output logic [BLOCK_WIDTH-1:0] dc_data_wb,
  output logic [CNT_WIDTH-1:0]   hit_count,
  output logic [CNT_WIDTH-1:0]   miss_count
);

  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITEBACK = 3'd1,
    ALLOCATE  = 3'd2
  } state_t;

  state_t state, state_nxt;

  logic [TAG_WIDTH-1:0]   tag_mem  [WAYS][SETS];
  logic [BLOCK_WIDTH-1:0] data_mem [WAYS][SETS];
  logic [SETS-1:0]        valid    [WAYS];
  logic [SETS-1:0]        dirty    [WAYS];
  logic [WAY_W-1:0]       rr_ptr   [SETS];

  logic [TAG_WIDTH-1:0]    req_tag;
  logic [INDEX_WIDTH-1:0]  req_index;
  logic [OFFSET_WIDTH-1:0] req_offset;
  logic                    req;

  logic [TAG_WIDTH-1:0]   tag_q;
  logic [INDEX_WIDTH-1:0] index_q;
  logic [WAY_W-1:0]       vict_q;
  logic                   by_ptr_q;
  logic                   retry_q;

  logic                   hit;
  logic [WAY_W-1:0]       hit_way;
  logic                   inv_found;
  logic [WAY_W-1:0]       vict_way;
  logic                   vict_dirty;
  logic [BLOCK_WIDTH-1:0] hit_block;
  logic [BLOCK_WIDTH-1:0] store_block;
  logic [DATA_WIDTH-1:0]  hit_word;
  logic                   stall_raw;
  logic                   lookup_hit;
  logic                   lookup_miss;
  logic                   do_store;
  logic                   refill_done;

  assign req_tag    = dc_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_index  = dc_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_offset = dc_addr[OFFSET_WIDTH-1:0];
  assign req        = dc_read_in | dc_write_in;

  assign lookup_hit  = (state == IDLE) && req && hit;
  assign lookup_miss = (state == IDLE) && req && !hit;
  assign do_store    = lookup_hit && dc_write_in;
  assign refill_done = (state == ALLOCATE) && ram_ready;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w][req_index] && tag_mem[w][req_index] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Descending scan leaves the lowest-numbered invalid way selected.
  always_comb begin
    inv_found = 1'b0;
    vict_way  = rr_ptr[req_index];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w][req_index]) begin
        inv_found = 1'b1;
        vict_way  = WAY_W'(w);
      end
    end
    vict_dirty = !inv_found && dirty[vict_way][req_index];
  end

  assign hit_block = data_mem[hit_way][req_index];

  always_comb begin
    hit_word    = '0;
    store_block = hit_block;
    for (int o = 0; o < BLOCK_SIZE; o++) begin
      if (req_offset == OFFSET_WIDTH'(o)) begin
        hit_word = hit_block[o*DATA_WIDTH +: DATA_WIDTH];
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (dc_byte_w_en_in[b])
            store_block[o*DATA_WIDTH + b*8 +: 8] = data_from_reg[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    stall_raw     = 1'b0;
    dc_data_out   = '0;
    ram_en_out    = 1'b0;
    ram_write_out = 1'b0;
    ram_addr_out  = '0;
    dc_data_wb    = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            dc_data_out = hit_word;
          end else begin
            stall_raw = 1'b1;
            state_nxt = vict_dirty ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        stall_raw     = 1'b1;
        ram_en_out    = 1'b1;
        ram_write_out = 1'b1;
        ram_addr_out  = {tag_mem[vict_q][index_q], index_q, {OFFSET_WIDTH{1'b0}}};
        dc_data_wb    = data_mem[vict_q][index_q];
        if (ram_ready) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        stall_raw    = 1'b1;
        ram_en_out   = 1'b1;
        ram_addr_out = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
        if (ram_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stall is held low while reset is asserted, even with a request pending.
  assign mem_stall = stall_raw & rst;
  assign status    = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int w = 0; w < WAYS; w++) begin
        valid[w] <= '0;
        dirty[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
      tag_q      <= '0;
      index_q    <= '0;
      vict_q     <= '0;
      by_ptr_q   <= 1'b0;
      retry_q    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      retry_q <= refill_done;
      if (lookup_miss) begin
        tag_q    <= req_tag;
        index_q  <= req_index;
        vict_q   <= vict_way;
        by_ptr_q <= !inv_found;
        if (miss_count != {CNT_WIDTH{1'b1}}) miss_count <= miss_count + CNT_WIDTH'(1);
      end
      if (lookup_hit && !retry_q && hit_count != {CNT_WIDTH{1'b1}})
        hit_count <= hit_count + CNT_WIDTH'(1);
      if (do_store) dirty[hit_way][req_index] <= 1'b1;
      if (refill_done) begin
        valid[vict_q][index_q] <= 1'b1;
        dirty[vict_q][index_q] <= 1'b0;
        if (by_ptr_q && WAYS > 1) rr_ptr[index_q] <= rr_ptr[index_q] + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (refill_done) begin
      data_mem[vict_q][index_q] <= block_from_ram;
      tag_mem[vict_q][index_q]  <= tag_q;
    end else if (do_store) begin
      data_mem[hit_way][req_index] <= store_block;
    end
  end

endmodule

// File: tb/tb_nway_dcache_ctrl.sv
// Randomised bench for nway_dcache_ctrl: a per-set cache-state model plus a flat
// word memory predict hits, victims, RAM traffic, load data and statistics.
module tb_nway_dcache_ctrl;

  localparam int WAYS = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         dc_read_in, dc_write_in;
  logic [3:0]   dc_byte_w_en_in;
  logic [29:0]  dc_addr;
  logic [31:0]  data_from_reg;
  logic         ram_ready;
  logic [255:0] block_from_ram;

  logic         mem_stall, ram_en_out, ram_write_out;
  logic [31:0]  dc_data_out;
  logic [2:0]   status;
  logic [29:0]  ram_addr_out;
  logic [255:0] dc_data_wb;
  logic [31:0]  hit_count, miss_count;

  logic         s_mem_stall, s_ram_en_out, s_ram_write_out;
  logic [31:0]  s_dc_data_out;
  logic [2:0]   s_status;
  logic [29:0]  s_ram_addr_out;
  logic [255:0] s_dc_data_wb;
  logic [1:0]   s_hit_count, s_miss_count;

  nway_dcache_ctrl #(.WAYS(WAYS)) dut (
    .clk(clk), .rst(rst), .dc_read_in(dc_read_in), .dc_write_in(dc_write_in),
    .dc_byte_w_en_in(dc_byte_w_en_in), .dc_addr(dc_addr), .data_from_reg(data_from_reg),
    .ram_ready(ram_ready), .block_from_ram(block_from_ram), .mem_stall(mem_stall),
    .dc_data_out(dc_data_out), .status(status), .ram_en_out(ram_en_out),
    .ram_write_out(ram_write_out), .ram_addr_out(ram_addr_out), .dc_data_wb(dc_data_wb),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Same stimulus, 2-bit counters to exercise saturation.
  nway_dcache_ctrl #(.WAYS(WAYS), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .dc_read_in(dc_read_in), .dc_write_in(dc_write_in),
    .dc_byte_w_en_in(dc_byte_w_en_in), .dc_addr(dc_addr), .data_from_reg(data_from_reg),
    .ram_ready(ram_ready), .block_from_ram(block_from_ram), .mem_stall(s_mem_stall),
    .dc_data_out(s_dc_data_out), .status(s_status), .ram_en_out(s_ram_en_out),
    .ram_write_out(s_ram_write_out), .ram_addr_out(s_ram_addr_out), .dc_data_wb(s_dc_data_wb),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] golden [logic [29:0]];
  logic [31:0] ram    [logic [29:0]];
  bit          m_valid [WAYS][64];
  bit          m_dirty [WAYS][64];
  logic [20:0] m_tag   [WAYS][64];
  int          m_rr    [64];
  longint      m_hits, m_misses;
  logic [31:0] last_dout;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic void touch_block(input logic [29:0] baddr);
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      if (!ram.exists(baddr + 30'(i))) begin
        v = $urandom;
        ram[baddr + 30'(i)]    = v;
        golden[baddr + 30'(i)] = v;
      end
    end
  endfunction

  function automatic logic [255:0] block_of(input bit from_ram, input logic [29:0] baddr);
    logic [255:0] blk;
    for (int i = 0; i < 8; i++)
      blk[i*32 +: 32] = from_ram ? ram[baddr + 30'(i)] : golden[baddr + 30'(i)];
    return blk;
  endfunction

  function automatic void model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < 64; s++) begin
        m_valid[w][s] = 0;
        m_dirty[w][s] = 0;
      end
    for (int s = 0; s < 64; s++) m_rr[s] = 0;
    m_hits   = 0;
    m_misses = 0;
    golden   = ram;
  endfunction

  task automatic check_counters();
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
    check("hit_count_sat", s_hit_count, (m_hits > 3) ? 3 : m_hits);
    check("miss_count_sat", s_miss_count, (m_misses > 3) ? 3 : m_misses);
  endtask

  // Entered and left just after a rising edge.
  task automatic access(input bit rd_i, input bit wr_i, input logic [29:0] a,
                        input logic [3:0] be_i, input logic [31:0] d_i,
                        input int n_wb, input int n_al, input bit drop, input bit rst_wb);
    logic [20:0] tg;
    logic [5:0]  ix;
    logic [29:0] baddr, vaddr;
    int          hw, vw;
    bit          hit, inv, vdirty;
    tg    = a[29:9];
    ix    = a[8:3];
    baddr = {a[29:3], 3'b000};
    touch_block(baddr);
    dc_read_in      = rd_i;
    dc_write_in     = wr_i;
    dc_addr         = a;
    dc_byte_w_en_in = be_i;
    data_from_reg   = d_i;
    ram_ready       = 1'($urandom_range(0, 1));
    hit = 0;
    hw  = 0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[w][ix] && m_tag[w][ix] == tg) begin
        hit = 1;
        hw  = w;
      end
    @(negedge clk);
    check("idle_status", status, 0);
    last_dout = dc_data_out;
    if (hit) begin
      check("hit_stall", mem_stall, 0);
      if (rd_i) check("hit_load_data", dc_data_out, golden[a]);
      @(posedge clk);
      if (wr_i) begin
        golden[a]      = merge(golden[a], d_i, be_i);
        m_dirty[hw][ix] = 1;
      end
      m_hits++;
      #1;
      check_counters();
      return;
    end
    check("miss_stall", mem_stall, 1);
    vw  = m_rr[ix];
    inv = 0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!m_valid[w][ix]) begin
        vw  = w;
        inv = 1;
      end
    vdirty = m_valid[vw][ix] && m_dirty[vw][ix];
    @(posedge clk);
    #1;
    m_misses++;
    if (drop) begin
      dc_read_in  = 0;
      dc_write_in = 0;
      dc_addr     = 30'($urandom);
    end
    if (vdirty) begin
      vaddr = {m_tag[vw][ix], ix, 3'b000};
      for (int k = 0; k < n_wb; k++) begin
        ram_ready = (k == n_wb - 1);
        @(negedge clk);
        check("wb_status", status, 1);
        check("wb_stall", mem_stall, 1);
        check("wb_ram_en", ram_en_out, 1);
        check("wb_ram_write", ram_write_out, 1);
        check("wb_ram_addr", ram_addr_out, vaddr);
        check("wb_block", dc_data_wb, block_of(0, vaddr));
        if (rst_wb) begin
          #2 rst = 0;
          #1;
          check("rst_ram_en", ram_en_out, 0);
          check("rst_status", status, 0);
          check("rst_stall", mem_stall, 0);
          check("rst_ram_addr", ram_addr_out, 0);
          model_reset();
          @(posedge clk);
          #1;
          rst         = 1;
          dc_read_in  = 0;
          dc_write_in = 0;
          ram_ready   = 0;
          return;
        end
        @(posedge clk);
        #1;
      end
      for (int i = 0; i < 8; i++) ram[vaddr + 30'(i)] = golden[vaddr + 30'(i)];
    end
    block_from_ram = block_of(1, baddr);
    for (int k = 0; k < n_al; k++) begin
      ram_ready = (k == n_al - 1);
      @(negedge clk);
      check("al_status", status, 2);
      check("al_stall", mem_stall, 1);
      check("al_ram_en", ram_en_out, 1);
      check("al_ram_write", ram_write_out, 0);
      check("al_ram_addr", ram_addr_out, baddr);
      @(posedge clk);
      #1;
    end
    block_from_ram = {8{$urandom}};
    m_valid[vw][ix] = 1;
    m_tag[vw][ix]   = tg;
    m_dirty[vw][ix] = 0;
    if (!inv) m_rr[ix] = (m_rr[ix] + 1) % WAYS;
    ram_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("retry_status", status, 0);
    check("retry_stall", mem_stall, 0);
    last_dout = dc_data_out;
    if (!drop) begin
      if (rd_i) check("retry_load_data", dc_data_out, golden[a]);
      @(posedge clk);
      if (wr_i) begin
        golden[a]       = merge(golden[a], d_i, be_i);
        m_dirty[vw][ix] = 1;
      end
    end else begin
      check("drop_idle_data", dc_data_out, 0);
      @(posedge clk);
    end
    #1;
    check_counters();
  endtask

  function automatic logic [29:0] mk_addr(input int tg, input int ix, input int off);
    return {21'(tg), 6'(ix), 3'(off)};
  endfunction

  initial begin
    logic [29:0] a;
    int          op, ix_sel, ix;
    rst = 0;
    dc_read_in = 0; dc_write_in = 0; dc_byte_w_en_in = 0; dc_addr = 0;
    data_from_reg = 0; ram_ready = 0; block_from_ram = 0;
    model_reset();
    #2;
    dc_read_in = 1;
    dc_addr    = 30'h40;
    #1;
    check("reset_stall", mem_stall, 0);
    check("reset_ram_en", ram_en_out, 0);
    check("reset_ram_write", ram_write_out, 0);
    check("reset_ram_addr", ram_addr_out, 0);
    check("reset_wb", dc_data_wb, 0);
    check("reset_dout", dc_data_out, 0);
    check("reset_status", status, 0);
    check_counters();
    @(posedge clk);
    #1;
    rst = 1;
    dc_read_in = 0;

    ram[30'h40]    = 32'h11223344;
    golden[30'h40] = 32'h11223344;
    access(1, 0, 30'h40, 4'h0, 32'h0, 1, 3, 0, 0);
    check("plan_first_word", last_dout, 32'h11223344);
    check("plan_hit0", hit_count, 0);
    check("plan_miss1", miss_count, 1);
    access(0, 1, 30'h40, 4'b0101, 32'hDEADBEEF, 1, 1, 0, 0);
    access(1, 0, 30'h40, 4'h0, 32'h0, 1, 1, 0, 0);
    check("plan_merge", last_dout, 32'h11AD33EF);
    check("plan_hit2", hit_count, 2);

    access(1, 0, mk_addr(1, 5, 2), 4'h0, 0, 1, 2, 0, 0);
    access(1, 0, mk_addr(2, 5, 3), 4'h0, 0, 1, 1, 0, 0);
    access(0, 1, mk_addr(1, 5, 4), 4'hF, 32'hCAFEF00D, 1, 1, 0, 0);
    access(1, 0, mk_addr(3, 5, 1), 4'h0, 0, 2, 2, 0, 0);
    access(1, 0, mk_addr(2, 5, 0), 4'h0, 0, 1, 1, 0, 0);
    access(1, 0, mk_addr(1, 5, 4), 4'h0, 0, 1, 1, 0, 0);
    access(1, 1, mk_addr(3, 5, 1), 4'b1010, 32'h5A5AA5A5, 1, 1, 0, 0);

    access(1, 0, mk_addr(4, 5, 6), 4'h0, 0, 3, 1, 0, 1);
    access(1, 0, mk_addr(3, 5, 1), 4'h0, 0, 1, 1, 0, 0);
    check("plan_rst_remiss", miss_count, 1);
    for (int i = 0; i < 5; i++) access(1, 0, mk_addr(3, 5, i), 4'h0, 0, 1, 1, 0, 0);
    check("plan_sat_hits", s_hit_count, 2'd3);

    for (int n = 0; n < 400; n++) begin
      op     = $urandom_range(0, 3);
      ix_sel = $urandom_range(0, 3);
      ix     = (ix_sel == 0) ? 5 : (ix_sel == 1) ? 8 : (ix_sel == 2) ? 9 : $urandom_range(0, 63);
      a      = mk_addr($urandom_range(0, 5), ix, $urandom_range(0, 7));
      access(op != 1, op == 1 || op == 2, a, 4'($urandom), $urandom,
             $urandom_range(1, 4), $urandom_range(1, 4),
             $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nway_dcache_ctrl.md
Name: nway_dcache_ctrl

Overview:
Parametrised N-way set-associative, write-back, write-allocate data-cache controller with its own tag, data, valid and dirty storage.
It sits between the core memory stage and the block-wide RAM port. It owns the mem_stall handshake directly.
Compared with the fixed 2-way unit, it generalises way count and data width, and adds round-robin replacement plus hit and miss statistics counters.

Parameters:
OFFSET_WIDTH, 3, word offset width within a block (BLOCK_SIZE = 2^OFFSET_WIDTH words)
INDEX_WIDTH, 6, set index width (SETS = 2^INDEX_WIDTH)
ADDR_WIDTH, 30, word address width
DATA_WIDTH, 32, word width in bits; multiple of 8
WAYS, 2, associativity; power of 2, range 1..8
CNT_WIDTH, 32, width of each statistics counter
Derived: BLOCK_WIDTH = DATA_WIDTH*BLOCK_SIZE; TAG_WIDTH = ADDR_WIDTH-OFFSET_WIDTH-INDEX_WIDTH; BE_WIDTH = DATA_WIDTH/8

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous active-low reset
dc_read_in  in  1  core load request
dc_write_in  in  1  core store request
dc_byte_w_en_in  in  BE_WIDTH  store byte enables; bit i selects byte i
dc_addr  in  ADDR_WIDTH  word address, split as {tag, index, offset}
data_from_reg  in  DATA_WIDTH  store data
ram_ready  in  1  RAM has completed the current block transfer (one-cycle pulse or held)
block_from_ram  in  BLOCK_WIDTH  refill block; valid while ram_ready=1 in ALLOCATE
mem_stall  out  1  core must hold its request
dc_data_out  out  DATA_WIDTH  load data
status  out  3  FSM state: 0 IDLE, 1 WRITEBACK, 2 ALLOCATE
ram_en_out  out  1  RAM access request
ram_write_out  out  1  1 = block write-back, 0 = block read
ram_addr_out  out  ADDR_WIDTH  block-aligned word address (offset bits 0)
dc_data_wb  out  BLOCK_WIDTH  victim block during WRITEBACK
hit_count  out  CNT_WIDTH  saturating count of first-attempt hits
miss_count  out  CNT_WIDTH  saturating count of misses

Behaviour:
- Reset (rst=0, asynchronous): all valid and dirty bits cleared; round-robin pointers = 0; state IDLE; both counters = 0. Outputs during and after reset: mem_stall=0, ram_en_out=0, ram_write_out=0, ram_addr_out=0, dc_data_wb=0, dc_data_out=0, status=0. Tag and data arrays are not reset.
- Request definition: req = dc_read_in | dc_write_in. If both are asserted, the access is treated as a store; dc_data_out still shows the pre-store word.
- Hit (IDLE, req, some valid way with a matching tag): mem_stall=0 combinationally in the same cycle.
  - Load: dc_data_out = the addressed word, combinational.
  - Store: enabled bytes are written and dirty is set at the clock edge.
  - A hit on more than one way cannot occur.
- No request: mem_stall=0, dc_data_out=0.
- Miss (IDLE, req, no matching way): mem_stall=1; miss_count increments at this edge.
  - Victim selection: the lowest-numbered invalid way; if all ways are valid, the way given by the set's round-robin pointer.
  - Victim dirty: go to WRITEBACK. Otherwise: go to ALLOCATE.
- WRITEBACK: ram_en_out=1, ram_write_out=1, ram_addr_out={victim tag, index, 0}, dc_data_wb=victim block, mem_stall=1.
  - Hold until ram_ready=1, then go to ALLOCATE.
- ALLOCATE: ram_en_out=1, ram_write_out=0, ram_addr_out={request tag, index, 0}, mem_stall=1.
  - On ram_ready=1: victim way gets block_from_ram, the new tag, valid=1, dirty=0.
  - The set's pointer advances by 1 modulo WAYS, but only if the victim was chosen by the pointer.
  - Go to IDLE.
- Retry: the cycle after refill is a hit on the first IDLE cycle. The store merge happens then. This hit is not counted in hit_count; an internal retry flag suppresses it.
- Miss penalty: clean = 1 + N_alloc cycles; dirty = 1 + N_wb + N_alloc cycles, where N is cycles until ram_ready.
- ram_ready held high: each state consumes one cycle, so minimum penalty is 2 (clean) or 3 (dirty).
- ram_ready while IDLE: ignored.
- Request dropped mid-miss: the FSM completes WRITEBACK and ALLOCATE anyway, then returns to IDLE with no store merge.
- Address changed mid-miss: ignored. The FSM uses the tag and index latched at miss detection.
- Reset mid-miss: immediate return to IDLE, RAM request dropped, any partial transfer discarded.
- Counters: saturate at all-ones, never wrap.
- WAYS=1: direct-mapped operation; the pointer is unused.

Test Plan:
- Reset, then load 0x0000040 with ram_ready pulsed 3 cycles after ALLOCATE entry. Required: miss_count=1, status 0→2→0, ram_addr_out=0x0000040, ram_write_out=0, stall for 4 cycles; the retry returns word 0 of the block; hit_count=0.
- Store 0xDEADBEEF with byte enables 4'b0101 to a resident word holding 0x11223344, then load it. Required: no stall on either access; load returns 0x11AD33EF; hit_count=2.
- With WAYS=2, fill index 5 with tags A and B, dirty A, then miss on tag C at the same index. Required: WRITEBACK with ram_addr_out={A,5,0} and dc_data_wb equal to A's block, then ALLOCATE {C,5,0}; way 0 is replaced and the pointer becomes 1.
- Assert both read and write on a hit. Required: the store is applied, dc_data_out shows the old word, mem_stall=0.
- Assert rst=0 during WRITEBACK. Required: ram_en_out=0 immediately; after release, a load of the previous address misses again.
- Force hit_count to all-ones minus 1 via CNT_WIDTH=2, then perform 5 hits. Required: hit_count stays at 3.
